lsr8_iter: RTL and testbench

- Multi-cycle 8-bit logical shift-right unit in the shifter8 group.
- Accepts an operand and a 0..7 shift amount over a valid/ready handshake.
- Shifts right by at most 3 positions per cycle, using a combinational 0..3-position right-shift stage.
- Returns the result over a valid/ready handshake; it is the right-shift counterpart of the left-shift datapath.

---
 rtl/shifter8_pkg.sv | 18 +
 rtl/lsr8_step.sv | 21 ++
 rtl/lsr8_iter.sv | 107 ++++++++++
 tb/tb_lsr8_iter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/shifter8_pkg.sv
// Shared constants, state encoding and mux helper for the shifter8 group.
package shifter8_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SHW   = 3;
  localparam int STEP_MAX  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  function automatic logic mux4(input logic [3:0] v, input logic [1:0] sel);
    return v[sel];
  endfunction

endpackage

// File: rtl/lsr8_step.sv
// Combinational 0..3-position right-shift stage; vacated MSBs take fill.
module lsr8_step
  import shifter8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] d_in,
  input  logic [1:0]       shamt,
  input  logic             fill,
  output logic [WIDTH-1:0] d_out
);

  // Operand extended with three fill bits so every bit sees a full 4:1 window.
  logic [WIDTH+2:0] ext;
  assign ext = {{3{fill}}, d_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign d_out[i] = mux4(ext[i+3:i], shamt);
  end

endmodule

// File: rtl/lsr8_iter.sv
// Multi-cycle logical shift-right unit, up to 3 positions per cycle.
// Define LSR8_ITER_ASR_EN to add the arith port (arithmetic shift right).
module lsr8_iter
  import shifter8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SHW-1:0]   shamt,
`ifdef LSR8_ITER_ASR_EN
  input  logic             arith,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       step;
  logic [WIDTH-1:0] stage_out;
  logic             fill;

  assign step = (rem_q > SHW'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];

  lsr8_step #(.WIDTH(WIDTH)) u_step (
    .d_in  (data_q),
    .shamt (step),
    .fill  (fill),
    .d_out (stage_out)
  );

`ifdef LSR8_ITER_ASR_EN
  // Fill bit is latched at accept so later changes on arith/d_in are ignored.
  logic fill_q, fill_d;
  assign fill = fill_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fill_q <= 1'b0;
    else       fill_q <= fill_d;
  end

  always_comb begin
    fill_d = fill_q;
    if (state_q == S_IDLE && in_valid) fill_d = arith & d_in[WIDTH-1];
  end
`else
  assign fill = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          data_d  = d_in;
          rem_d   = shamt;
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = stage_out;
        rem_d  = rem_q - SHW'(step);
        if (rem_q <= SHW'(STEP_MAX)) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result stays on d_out after the handshake until the next accept.
  assign d_out = data_q;

endmodule

// File: tb/tb_lsr8_iter.sv
// Self-checking bench for lsr8_iter: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_lsr8_iter;

`ifdef LSR8_ITER_ASR_EN
  localparam bit ASR = 1'b1;
`else
  localparam bit ASR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, busy, arith;
  logic [7:0] d_in, d_out;
  logic [2:0] shamt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsr8_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .shamt     (shamt),
`ifdef LSR8_ITER_ASR_EN
    .arith     (arith),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Floor division of the (optionally signed) operand by 2^sh.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int sh, input bit ar);
    int v;
    int p;
    p = 1 << sh;
    v = (ar && d[7]) ? int'(d) - 256 : int'(d);
    if (v < 0) v = -((-v + p - 1) / p);
    else       v = v / p;
    return 8'(v);
  endfunction

  task automatic run_op(input string tag, input logic [7:0] d, input int sh,
                        input bit ar, input int hold);
    int         lat;
    logic [7:0] exp;
    exp = ref_shift(d, sh, ASR && ar);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    d_in      = d;
    shamt     = 3'(sh);
    arith     = ar;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    d_in     = 8'($urandom);
    shamt    = 3'($urandom);
    arith    = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(1 + (sh + 2) / 3));
    check({tag, "_data"}, 32'(d_out), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(d_out), 32'(exp));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      d_in     = 8'($urandom);
      shamt    = 3'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
    check({tag, "_post_data"}, 32'(d_out), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d_in      = 8'h00;
    shamt     = 3'd0;
    arith     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_d_out", 32'(d_out), 32'h00);

    run_op("b6_sh0", 8'hB6, 0, 1'b0, 0);
    run_op("ff_sh7", 8'hFF, 7, 1'b0, 0);
    run_op("f0_sh4_bp", 8'hF0, 4, 1'b0, 5);
    run_op("x_sh3", 8'hA5, 3, 1'b0, 1);

    // Abort: reset during the second SHIFT cycle of a 7-position shift.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    d_in      = 8'h80;
    shamt     = 3'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d_out", 32'(d_out), 32'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_hold_valid", 32'(out_valid), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_after_valid", 32'(out_valid), 32'd0);
    end
    run_op("after_abort", 8'h40, 1, 1'b0, 0);

    if (ASR) begin
      run_op("asr_90_sh5", 8'h90, 5, 1'b1, 0);
      run_op("lsr_90_sh5", 8'h90, 5, 1'b0, 0);
      for (int s = 0; s < 8; s++) run_op("asr_sweep", 8'h81, s, 1'b1, 0);
    end

    for (int s = 0; s < 8; s++) run_op("sweep", 8'($urandom), s, 1'b0, s % 2);

    for (int i = 0; i < 40; i++)
      run_op("rand", 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
             int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
